// File: rtl/tetris_input_pkg.sv
// Shared definitions for the Tetris button input path:
// button indices, default button count and id type.
package tetris_input_pkg;

  localparam int DEFAULT_NUM_BTN = 5;

  localparam int BTN_LEFT      = 0;
  localparam int BTN_RIGHT     = 1;
  localparam int BTN_ROTATE    = 2;
  localparam int BTN_SOFT_DROP = 3;
  localparam int BTN_HARD_DROP = 4;

  typedef logic [$clog2(DEFAULT_NUM_BTN)-1:0] btn_id_t;

  // Hold counter must fit the larger of the two reload values.
  function automatic int hold_w(int d, int p);
    int m;
    m = (d > p) ? d : p;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_scheduler_key_repeat_timer.sv
// Per-button press detector and hold timer.
// Repeat logic exists only when AUTO_REPEAT_EN is defined.
module key_repeat_timer
  import tetris_input_pkg::*;
#(
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_q,
  input  logic btn_q_prev,
  output logic press,
  output logic rpt,
  output logic [hold_w(REPEAT_DELAY, REPEAT_PERIOD)-1:0] hold_cnt
);

  localparam int HW = hold_w(REPEAT_DELAY, REPEAT_PERIOD);

  assign press = tick & btn_q & ~btn_q_prev;

`ifdef AUTO_REPEAT_EN
  logic [HW-1:0] hold_cnt_q;
  logic [HW-1:0] hold_cnt_d;
  logic          held;

  assign held = tick & btn_q & btn_q_prev;
  assign rpt  = held & (hold_cnt_q == HW'(1));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (tick) begin
      if (press) begin
        hold_cnt_d = HW'(REPEAT_DELAY);
      end else if (btn_q) begin
        if (hold_cnt_q == HW'(1)) begin
          hold_cnt_d = HW'(REPEAT_PERIOD);
        end else if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
      end else begin
        hold_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign hold_cnt = hold_cnt_q;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst;
  assign rpt            = 1'b0;
  assign hold_cnt       = '0;
`endif

endmodule

// File: rtl/button_scheduler.sv
// Samples debounced buttons on a slow tick and grants press/repeat
// events round-robin; define AUTO_REPEAT_EN to build auto-repeat.
module button_scheduler
  import tetris_input_pkg::*;
#(
  parameter int NUM_BTN       = DEFAULT_NUM_BTN,
  parameter int TICK_DIV      = 10000,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_level,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [$clog2(NUM_BTN)-1:0] cmd_id,
  output logic                       cmd_repeat,
  output logic [NUM_BTN-1:0]         pending
);

  localparam int IDW = $clog2(NUM_BTN);
  localparam int CW  = $clog2(TICK_DIV);
  localparam int HW  = hold_w(REPEAT_DELAY, REPEAT_PERIOD);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               tick;
  logic [NUM_BTN-1:0] btn_q, btn_d;
  logic [NUM_BTN-1:0] btn_prev_q, btn_prev_d;
  logic [NUM_BTN-1:0] pend_q, pend_d;
  logic [NUM_BTN-1:0] rep_q, rep_d;
  logic [NUM_BTN-1:0] press, rpt;
  logic [NUM_BTN-1:0][HW-1:0] hold_cnt;

  logic               valid_q, valid_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               cmd_rep_q, cmd_rep_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic               load;
  logic               gnt_found;
  logic [IDW-1:0]     gnt_idx;
  logic               unused_hold;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + CW'(1);
    btn_d      = btn_q;
    btn_prev_d = btn_prev_q;
    if (tick) begin
      btn_d      = btn_level;
      btn_prev_d = btn_q;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    key_repeat_timer #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .btn_q     (btn_q[i]),
      .btn_q_prev(btn_prev_q[i]),
      .press     (press[i]),
      .rpt       (rpt[i]),
      .hold_cnt  (hold_cnt[i])
    );
  end

  // First pending index strictly after the last grant, wrapping.
  always_comb begin
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_BTN) j = j - NUM_BTN;
      if (!gnt_found && pend_q[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(j);
      end
    end
  end

  assign load = ~valid_q | cmd_ready;

  always_comb begin
    valid_d   = valid_q;
    id_d      = id_q;
    cmd_rep_d = cmd_rep_q;
    rr_d      = rr_q;
    if (load) begin
      valid_d = gnt_found;
      if (gnt_found) begin
        id_d      = gnt_idx;
        cmd_rep_d = rep_q[gnt_idx];
        rr_d      = gnt_idx;
      end
    end
  end

  // Clears first, then new events, so a same-cycle set survives a grant.
  always_comb begin
    pend_d = pend_q;
    rep_d  = rep_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (tick && !btn_q[i] && rep_q[i]) begin
        pend_d[i] = 1'b0;
        rep_d[i]  = 1'b0;
      end
      if (load && gnt_found && (gnt_idx == IDW'(i))) begin
        pend_d[i] = 1'b0;
        rep_d[i]  = 1'b0;
      end
      if (press[i]) begin
        pend_d[i] = 1'b1;
        rep_d[i]  = 1'b0;
      end else if (rpt[i]) begin
        rep_d[i]  = rep_d[i] | ~pend_d[i];
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      btn_q      <= '0;
      btn_prev_q <= '0;
      pend_q     <= '0;
      rep_q      <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      cmd_rep_q  <= 1'b0;
      rr_q       <= IDW'(NUM_BTN - 1);
    end else begin
      cnt_q      <= cnt_d;
      btn_q      <= btn_d;
      btn_prev_q <= btn_prev_d;
      pend_q     <= pend_d;
      rep_q      <= rep_d;
      valid_q    <= valid_d;
      id_q       <= id_d;
      cmd_rep_q  <= cmd_rep_d;
      rr_q       <= rr_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_id    = id_q;
  assign pending   = pend_q;

`ifdef AUTO_REPEAT_EN
  assign cmd_repeat  = cmd_rep_q;
  assign unused_hold = ^hold_cnt;
`else
  assign cmd_repeat  = 1'b0;
  assign unused_hold = ^{hold_cnt, cmd_rep_q};
`endif

endmodule

// File: tb/tb_button_scheduler.sv
// Bench for button_scheduler: tick-level behavioural model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_button_scheduler;
  import tetris_input_pkg::*;

  localparam int NB = 5;
  localparam int TD = 4;
  localparam int RD = 3;
  localparam int RP = 2;
`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_level;
  logic          cmd_ready;
  logic          cmd_valid;
  logic [2:0]    cmd_id;
  logic          cmd_repeat;
  logic [NB-1:0] pending;

  int checks   = 0;
  int failures = 0;
  int gcyc     = 0;

  always #5 clk = ~clk;

  button_scheduler #(
    .NUM_BTN      (NB),
    .TICK_DIV     (TD),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_level (btn_level),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_id    (cmd_id),
    .cmd_repeat(cmd_repeat),
    .pending   (pending)
  );

  // Model: cycles since reset, sampled levels, ticks held since press.
  int m_cyc;
  bit m_samp[NB];
  bit m_prev[NB];
  int m_held[NB];
  bit m_pend[NB];
  bit m_rep[NB];
  bit m_v;
  int m_id;
  bit m_r;
  int m_rr;

  int xid[$];
  int xrep[$];
  int xcyc[$];

  function automatic void m_reset();
    m_cyc = 0;
    m_v   = 1'b0;
    m_id  = 0;
    m_r   = 1'b0;
    m_rr  = NB - 1;
    for (int i = 0; i < NB; i++) begin
      m_samp[i] = 1'b0;
      m_prev[i] = 1'b0;
      m_held[i] = -1;
      m_pend[i] = 1'b0;
      m_rep[i]  = 1'b0;
    end
  endfunction

  // Advance the model across the coming rising edge.
  function automatic void m_step();
    bit np[NB];
    bit nr[NB];
    bit fresh[NB];
    bit rp[NB];
    bit tk;
    bit ld;
    int g;
    tk = ((m_cyc % TD) == TD - 1);
    ld = !m_v || cmd_ready;
    g  = -1;
    if (ld) begin
      for (int k = 1; k <= NB; k++) begin
        if (g < 0 && m_pend[(m_rr + k) % NB]) g = (m_rr + k) % NB;
      end
    end
    for (int i = 0; i < NB; i++) begin
      np[i] = m_pend[i];
      nr[i] = m_rep[i];
      fresh[i] = 1'b0;
      rp[i] = 1'b0;
      if (tk) begin
        if (m_samp[i] && !m_prev[i]) begin
          fresh[i]  = 1'b1;
          m_held[i] = 0;
        end else if (m_samp[i]) begin
          if (m_held[i] >= 0) begin
            m_held[i]++;
            if (AUTO && m_held[i] >= RD && ((m_held[i] - RD) % RP) == 0)
              rp[i] = 1'b1;
          end
        end else begin
          m_held[i] = -1;
          if (m_rep[i]) begin
            np[i] = 1'b0;
            nr[i] = 1'b0;
          end
        end
      end
    end
    if (ld) begin
      if (g >= 0) begin
        m_v   = 1'b1;
        m_id  = g;
        m_r   = m_rep[g];
        m_rr  = g;
        np[g] = 1'b0;
        nr[g] = 1'b0;
      end else begin
        m_v = 1'b0;
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (fresh[i]) begin
        np[i] = 1'b1;
        nr[i] = 1'b0;
      end else if (rp[i]) begin
        if (!np[i]) nr[i] = 1'b1;
        np[i] = 1'b1;
      end
      m_pend[i] = np[i];
      m_rep[i]  = nr[i];
      if (tk) begin
        m_prev[i] = m_samp[i];
        m_samp[i] = btn_level[i];
      end
    end
    m_cyc++;
  endfunction

  always @(negedge clk) begin
    logic [NB-1:0] ep;
    if (rst) m_reset();
    for (int i = 0; i < NB; i++) ep[i] = m_pend[i];
    checks++;
    if (cmd_valid !== m_v || pending !== ep ||
        (m_v && (cmd_id !== 3'(m_id) || cmd_repeat !== m_r))) begin
      failures++;
      $display("FAIL model_cycle t=%0t valid=%b/%b id=%0d/%0d rep=%b/%b pend=%b/%b actual/required",
               $time, cmd_valid, m_v, cmd_id, m_id, cmd_repeat, m_r, pending, ep);
    end
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        xid.push_back(int'(cmd_id));
        xrep.push_back(int'(cmd_repeat));
        xcyc.push_back(gcyc);
      end
      m_step();
    end
    gcyc++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr_log();
    xid.delete();
    xrep.delete();
    xcyc.delete();
  endtask

  function automatic int qget(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst       = 1'b1;
    btn_level = 5'b00001;
    cmd_ready = 1'b1;

    // 1: reset with button 0 held, then one fresh command for it
    cyc(5);
    chk("t1_valid_in_reset", int'(cmd_valid), 0);
    chk("t1_pending_in_reset", int'(pending), 0);
    clr_log();
    rst = 1'b0;
    r0  = gcyc;
    cyc(12);
    btn_level = '0;
    cyc(16);
    chk("t1_count", xid.size(), 1);
    chk("t1_id", qget(xid, 0), 0);
    chk("t1_rep", qget(xrep, 0), 0);
    chk("t1_first_cycle", qget(xcyc, 0) - r0, 9);

    // 2: buttons 1 and 3 together
    clr_log();
    btn_level = 5'b01010;
    cyc(10);
    btn_level = '0;
    cyc(16);
    chk("t2_count", xid.size(), 2);
    chk("t2_first_id", qget(xid, 0), 1);
    chk("t2_second_id", qget(xid, 1), 3);
    chk("t2_gap", qget(xcyc, 1) - qget(xcyc, 0), 1);
    chk("t2_pending", int'(pending), 0);

    // 3: hold button 0 for 10 ticks
    clr_log();
    btn_level = 5'b00001;
    cyc(40);
    btn_level = '0;
    cyc(20);
    chk("t3_first_rep", qget(xrep, 0), 0);
`ifdef AUTO_REPEAT_EN
    chk("t3_count", xid.size(), 5);
    chk("t3_rep1", qget(xrep, 1), 1);
    chk("t3_rep4", qget(xrep, 4), 1);
    chk("t3_delay", qget(xcyc, 1) - qget(xcyc, 0), 12);
    chk("t3_period", qget(xcyc, 2) - qget(xcyc, 1), 8);
    chk("t3_period_last", qget(xcyc, 4) - qget(xcyc, 3), 8);
`else
    chk("t3_count", xid.size(), 1);
`endif

    // 4: stall with button 2 in the output, button 4 waits
    clr_log();
    cmd_ready = 1'b0;
    btn_level = 5'b00100;
    cyc(12);
    btn_level = 5'b10000;
    cyc(8);
    btn_level = '0;
    cyc(8);
    chk("t4_valid", int'(cmd_valid), 1);
    chk("t4_id_held", int'(cmd_id), 2);
    chk("t4_pending", int'(pending), 5'b10000);
    cmd_ready = 1'b1;
    cyc(1);
    chk("t4_next_valid", int'(cmd_valid), 1);
    chk("t4_next_id", int'(cmd_id), 4);
    cyc(16);
    chk("t4_count", xid.size(), 2);

    // 5: two presses of button 0 while stalled coalesce
    clr_log();
    cmd_ready = 1'b0;
    btn_level = 5'b00010;
    cyc(12);
    btn_level = 5'b00001;
    cyc(8);
    btn_level = '0;
    cyc(8);
    btn_level = 5'b00001;
    cyc(8);
    btn_level = '0;
    cyc(8);
    chk("t5_stalled_id", int'(cmd_id), 1);
    chk("t5_pending", int'(pending), 5'b00001);
    cmd_ready = 1'b1;
    cyc(16);
    chk("t5_count", xid.size(), 2);
    chk("t5_second_id", qget(xid, 1), 0);

    // 6: reset with a command in flight and an event pending
    cmd_ready = 1'b0;
    btn_level = 5'b00100;
    cyc(12);
    btn_level = 5'b01000;
    cyc(8);
    btn_level = '0;
    cyc(4);
    chk("t6_pre_valid", int'(cmd_valid), 1);
    chk("t6_pre_pending", int'(pending), 5'b01000);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", int'(cmd_valid), 0);
    chk("t6_rst_pending", int'(pending), 0);
    chk("t6_rst_id", int'(cmd_id), 0);
    cyc(3);
    rst = 1'b0;
    cmd_ready = 1'b1;
    clr_log();
    cyc(24);
    chk("t6_no_replay", xid.size(), 0);
    chk("t6_valid_after", int'(cmd_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
